// File: rtl/vga_logo_pkg.sv
// Shared definitions for the bouncing VGA logo.
//
// Contents:
//   motion_state_t : motion FSM states (IDLE, STEP_X, STEP_Y)
//   axis_step_t    : result of one axis step (new position and wall-hit flag)
//   RING_IN/OUT    : inner/outer ring radii and their squares
//   HAT0..CUT1     : rectangles of the logo artwork (half-open [x0,x1) x [y0,y1))
//   PALETTE        : 8 foreground colours, 2 bits per channel, {R,G,B}
//   in_rect()      : rectangle membership helper
//
// All artwork coordinates are laid out on the 240 x 240 logo bounding box,
// with the origin at the top-left corner of the box.
package vga_logo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP_X = 2'd1,
      STEP_Y = 2'd2
   } motion_state_t;

   typedef struct packed {
      logic [9:0] pos;
      logic       hit;
   } axis_step_t;

   typedef struct packed {
      logic [9:0] x0;
      logic [9:0] y0;
      logic [9:0] x1;
      logic [9:0] y1;
   } rect_t;

   localparam int RING_IN  = 101;
   localparam int RING_OUT = 119;
   localparam logic [21:0] RING_IN_SQ  = 22'(RING_IN * RING_IN);
   localparam logic [21:0] RING_OUT_SQ = 22'(RING_OUT * RING_OUT);

   // Hat: a wide brim with a narrower crown sitting on top of it.
   localparam rect_t HAT0 = '{x0: 10'd70,  y0: 10'd40,  x1: 10'd170, y1: 10'd48};
   localparam rect_t HAT1 = '{x0: 10'd95,  y0: 10'd22,  x1: 10'd145, y1: 10'd40};
   // Legs hanging from the centre towards the bottom of the box.
   localparam rect_t LEG0 = '{x0: 10'd80,  y0: 10'd150, x1: 10'd96,  y1: 10'd236};
   localparam rect_t LEG1 = '{x0: 10'd144, y0: 10'd150, x1: 10'd160, y1: 10'd236};
   // Gaps punched through the left and right sides of the ring.
   localparam rect_t CUT0 = '{x0: 10'd0,   y0: 10'd112, x1: 10'd24,  y1: 10'd128};
   localparam rect_t CUT1 = '{x0: 10'd216, y0: 10'd112, x1: 10'd240, y1: 10'd128};

   // Index 0 is the last element of the concatenation.
   localparam logic [7:0][5:0] PALETTE = {
      6'b101010,   // 7 grey
      6'b001111,   // 6 cyan
      6'b110011,   // 5 magenta
      6'b111100,   // 4 yellow
      6'b000011,   // 3 blue
      6'b001100,   // 2 green
      6'b110000,   // 1 red
      6'b000000    // 0 black
   };

   function automatic logic in_rect(input rect_t r, input logic [9:0] x, input logic [9:0] y);
      return (x >= r.x0) && (x < r.x1) && (y >= r.y0) && (y < r.y1);
   endfunction

endpackage

// File: rtl/vga_logo_bouncer_logo_shape.sv
// logo_shape: combinational membership test for the logo artwork.
//
// Ports:
//   rel_x, rel_y : coordinate relative to the bounding-box top-left corner
//                  (caller guarantees it lies inside the box)
//   member       : 1 when the coordinate belongs to the logo foreground
//
// Membership = (ring AND NOT cut0 AND NOT cut1) OR hat0 OR hat1 OR leg0 OR leg1.
// The ring is an exact squared-distance test against the box centre.
module logo_shape
   import vga_logo_pkg::*;
#(
   parameter int LOGO_W = 240,
   parameter int LOGO_H = 240
) (
   input  logic [9:0] rel_x,
   input  logic [9:0] rel_y,
   output logic       member
);

   localparam logic signed [10:0] CENTRE_X = 11'(LOGO_W / 2);
   localparam logic signed [10:0] CENTRE_Y = 11'(LOGO_H / 2);

   logic signed [10:0] diff_x;
   logic signed [10:0] diff_y;
   logic signed [21:0] ext_x;
   logic signed [21:0] ext_y;
   logic signed [21:0] sq_x;
   logic signed [21:0] sq_y;
   logic        [21:0] dist_sq;
   logic               ring;

   always_comb begin
      diff_x  = $signed({1'b0, rel_x}) - CENTRE_X;
      diff_y  = $signed({1'b0, rel_y}) - CENTRE_Y;
      // Sign-extend before squaring so the product keeps full precision.
      ext_x   = diff_x;
      ext_y   = diff_y;
      sq_x    = ext_x * ext_x;
      sq_y    = ext_y * ext_y;
      // Squares are non-negative and each fits in 21 bits, so the sum cannot overflow.
      dist_sq = $unsigned(sq_x) + $unsigned(sq_y);
      ring    = (dist_sq > RING_IN_SQ) && (dist_sq < RING_OUT_SQ);
      member  = (ring && !in_rect(CUT0, rel_x, rel_y) && !in_rect(CUT1, rel_x, rel_y))
                || in_rect(HAT0, rel_x, rel_y) || in_rect(HAT1, rel_x, rel_y)
                || in_rect(LEG0, rel_x, rel_y) || in_rect(LEG1, rel_x, rel_y);
   end

endmodule

// File: rtl/vga_logo_bouncer.sv
// vga_logo_bouncer: draws a logo that bounces around the visible VGA area.
//
// Ports:
//   clk         : single rising-edge clock
//   reset       : synchronous, active-high reset
//   hpos, vpos  : current pixel column / row from the timing generator
//   display_on  : high inside the visible area
//   frame_tick  : one-cycle pulse at the first vertical-blank line
//   pause       : high freezes the motion
//   rgb         : registered {R,G,B} pixel, COLOR_BITS per channel, MSB first
//   logo_x/y    : bounding-box top-left position
//   bounce      : one-cycle pulse when the logo hits any wall
//
// Build option: define LOGO_COLOR_CYCLE_EN to step through an 8-colour palette
// on every bounce; without it the logo is drawn in black.
//
// Motion happens in a three-state walk (IDLE -> STEP_X -> STEP_Y -> IDLE)
// started by frame_tick, which lands in vertical blank so a frame never
// shows a half-updated position.
module vga_logo_bouncer
   import vga_logo_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int LOGO_W     = 240,
   parameter int LOGO_H     = 240,
   parameter int SPEED      = 1,
   parameter int COLOR_BITS = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [9:0]              hpos,
   input  logic [9:0]              vpos,
   input  logic                    display_on,
   input  logic                    frame_tick,
   input  logic                    pause,
   output logic [3*COLOR_BITS-1:0] rgb,
   output logic [9:0]              logo_x,
   output logic [9:0]              logo_y,
   output logic                    bounce
);

   localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - LOGO_W);
   localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - LOGO_H);
   localparam logic [9:0]  X_HOME  = 10'((H_ACTIVE - LOGO_W) / 2);
   localparam logic [9:0]  Y_HOME  = 10'((V_ACTIVE - LOGO_H) / 2);
   localparam logic [9:0]  STEP    = 10'(SPEED);
   localparam logic [10:0] BOX_W   = 11'(LOGO_W);
   localparam logic [10:0] BOX_H   = 11'(LOGO_H);

   // One axis move: advance by STEP, clamping to the wall and reporting a hit.
   function automatic axis_step_t step_axis(input logic [9:0] pos, input logic neg,
                                            input logic [9:0] limit);
      axis_step_t r;
      r.pos = pos;
      r.hit = 1'b0;
      if (!neg) begin
         if (({1'b0, pos} + {1'b0, STEP}) >= {1'b0, limit}) begin
            r.pos = limit;
            r.hit = 1'b1;
         end else begin
            r.pos = pos + STEP;
         end
      end else if (pos <= STEP) begin
         r.pos = '0;
         r.hit = 1'b1;
      end else begin
         r.pos = pos - STEP;
      end
      return r;
   endfunction

   motion_state_t state;
   logic          dx_neg;
   logic          dy_neg;
   logic          hit_x;
   axis_step_t    x_step;
   axis_step_t    y_step;

   logic [10:0]               rel_x_full;
   logic [10:0]               rel_y_full;
   logic                      in_box;
   logic                      member;
   logic [3*COLOR_BITS-1:0]   fg;

   always_comb begin
      x_step = step_axis(logo_x, dx_neg, X_MAX);
      y_step = step_axis(logo_y, dy_neg, Y_MAX);
   end

   // ---- motion FSM ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         logo_x <= X_HOME;
         logo_y <= Y_HOME;
         dx_neg <= 1'b0;
         dy_neg <= 1'b0;
         hit_x  <= 1'b0;
         bounce <= 1'b0;
      end else begin
         bounce <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_tick && !pause) state <= STEP_X;
            end
            STEP_X: begin
               logo_x <= x_step.pos;
               hit_x  <= x_step.hit;
               if (x_step.hit) dx_neg <= ~dx_neg;
               state  <= STEP_Y;
            end
            STEP_Y: begin
               logo_y <= y_step.pos;
               if (y_step.hit) dy_neg <= ~dy_neg;
               // A corner hit sets both flags but still yields a single pulse.
               bounce <= hit_x | y_step.hit;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LOGO_COLOR_CYCLE_EN
   // Stretch each 2-bit palette channel to COLOR_BITS by repeating its bits.
   function automatic logic [3*COLOR_BITS-1:0] expand_color(input logic [5:0] c);
      logic [3*COLOR_BITS-1:0] out;
      out = '0;
      for (int ch = 0; ch < 3; ch++) begin
         for (int k = 0; k < COLOR_BITS; k++) begin
            out[ch*COLOR_BITS + COLOR_BITS - 1 - k] = c[ch*2 + 1 - (k % 2)];
         end
      end
      return out;
   endfunction

   logic [2:0] color_idx;

   // Advances on the same edge that raises bounce, so it moves once per pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         color_idx <= '0;
      end else if (state == STEP_Y && (hit_x || y_step.hit)) begin
         color_idx <= color_idx + 3'd1;
      end
   end

   always_comb fg = expand_color(PALETTE[color_idx]);
`else
   always_comb fg = '0;
`endif

   // Relative coordinate; bit 10 set means the pixel lies left of / above the box.
   always_comb begin
      rel_x_full = {1'b0, hpos} - {1'b0, logo_x};
      rel_y_full = {1'b0, vpos} - {1'b0, logo_y};
      in_box     = !rel_x_full[10] && !rel_y_full[10]
                   && (rel_x_full < BOX_W) && (rel_y_full < BOX_H);
   end

   logo_shape #(
      .LOGO_W (LOGO_W),
      .LOGO_H (LOGO_H)
   ) u_shape (
      .rel_x  (rel_x_full[9:0]),
      .rel_y  (rel_y_full[9:0]),
      .member (member)
   );

   // ---- pixel output register ----
   always_ff @(posedge clk) begin
      if (reset || !display_on) begin
         rgb <= '0;
      end else if (in_box && member) begin
         rgb <= fg;
      end else begin
         rgb <= '1;
      end
   end

endmodule

// File: doc/vga_logo_bouncer.md
VGA_LOGO_BOUNCER -- requirements
Module: vga_logo_bouncer

Interface
REQ-001 SHALL expose parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL expose parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 SHALL expose parameter LOGO_W, default 240: logo bounding-box width in pixels.
REQ-004 SHALL expose parameter LOGO_H, default 240: logo bounding-box height in pixels.
REQ-005 SHALL expose parameter SPEED, default 1: pixels moved per axis per frame.
REQ-006 SHALL expose parameter COLOR_BITS, default 2: bits per colour channel.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port hpos, input, 10: current pixel column from the timing generator.
REQ-010 SHALL have port vpos, input, 10: current pixel row from the timing generator.
REQ-011 SHALL have port display_on, input, 1: high in the visible area.
REQ-012 SHALL have port frame_tick, input, 1: one-cycle pulse at the first vertical-blank line.
REQ-013 SHALL have port pause, input, 1: high freezes motion.
REQ-014 SHALL have port rgb, output, 3*COLOR_BITS: {R,G,B}, MSB-first per channel.
REQ-015 SHALL have ports logo_x and logo_y, output, 10 each: bounding-box top-left position.
REQ-016 SHALL have port bounce, output, 1: one-cycle pulse when the logo hits any wall.

Function
REQ-017 SHALL register rgb, giving 1-cycle latency from hpos/vpos/display_on to rgb.
REQ-018 SHALL drive rgb to 0 on the cycle after display_on is low.
REQ-019 SHALL evaluate logo membership on the relative coordinate (hpos-logo_x, vpos-logo_y); pixels outside the box are background.
REQ-020 Logo membership SHALL be (ring AND NOT cut0 AND NOT cut1) OR hat0 OR hat1 OR leg0 OR leg1.
REQ-021 Ring SHALL be exact squared distance to the box centre, strictly between RING_IN^2 and RING_OUT^2, using 11-bit signed differences and 22-bit unsigned sums.
REQ-022 Logo pixels SHALL be fg; others SHALL be all-ones (white).
REQ-023 The motion FSM SHALL have states IDLE, STEP_X, STEP_Y.
REQ-024 IDLE SHALL move to STEP_X on frame_tick when pause is low; otherwise it stays in IDLE.
REQ-025 STEP_X SHALL always move to STEP_Y, and STEP_Y SHALL always move to IDLE, one cycle each.
REQ-026 frame_tick in STEP_X or STEP_Y SHALL be ignored.
REQ-027 In STEP_X, with dx=+: if logo_x+SPEED >= H_ACTIVE-LOGO_W, logo_x SHALL be set to H_ACTIVE-LOGO_W, dx flipped and a hit flag set; else logo_x SHALL increase by SPEED.
REQ-028 In STEP_X, with dx=-: if logo_x <= SPEED, logo_x SHALL be set to 0, dx flipped and the hit flag set; else logo_x SHALL decrease by SPEED.
REQ-029 STEP_Y SHALL apply the same rule to logo_y, dy and V_ACTIVE-LOGO_H.
REQ-030 bounce SHALL pulse for exactly one cycle on the IDLE-return edge if either axis hit; a corner hit SHALL give one pulse only.
REQ-031 Position SHALL change only in STEP states, so a frame is never torn.

Reset
REQ-032 On reset: logo_x=(H_ACTIVE-LOGO_W)/2, logo_y=(V_ACTIVE-LOGO_H)/2, dx=dy=+, state IDLE.
REQ-033 On reset: rgb=0, bounce=0, colour index=0.
REQ-034 Reset during STEP_X or STEP_Y SHALL abort the step with no partial update.

Configuration
REQ-035 With LOGO_COLOR_CYCLE_EN defined: a 3-bit colour index SHALL increment (wrapping 7->0) on every bounce pulse, and fg SHALL be PALETTE[index].
REQ-036 With LOGO_COLOR_CYCLE_EN undefined: fg SHALL be all-zeros (black), and no index register SHALL exist.

Structure
REQ-037 Package vga_logo_pkg SHALL hold the following, all scaled to LOGO_W x LOGO_H:
- RING_IN=101 and RING_OUT=119;
- rectangle constants for hat0, hat1, leg0, leg1, cut0 and cut1;
- the 8-entry PALETTE;
- the FSM state typedef.
REQ-038 Combinational sub-module logo_shape SHALL map a relative coordinate to the membership bit; the FSM, registers and palette SHALL stay in the top level.

Verification
REQ-039 Reset, then hold idle -> logo_x=200, logo_y=120, rgb=0, bounce=0.
REQ-040 After reset, display_on=1, hpos=320, vpos=125 -> next cycle rgb=fg (ring); hpos=200, vpos=120 -> next cycle rgb=6'b111111.
REQ-041 Apply 120 frame_ticks -> logo_x=320, logo_y=240, one bounce pulse at tick 120, dy negative; tick 121 gives logo_y=239.
REQ-042 Assert pause across 10 frame_ticks -> position unchanged, no bounce pulse.
REQ-043 Force a corner hit (set the start position so both axes reach their limits on the same tick) -> one bounce pulse, both directions flipped; with LOGO_COLOR_CYCLE_EN, colour index +1 only.
REQ-044 Assert reset in STEP_X -> the next cycle shows the REQ-032/REQ-033 values; display_on=0 -> rgb=0 on the following cycle.
